logic_eval_arbiter: RTL and testbench



---
 rtl/logic_eval_arbiter_pkg.sv | 18 +
 rtl/logic_eval_arbiter_fgh.sv | 39 +++
 rtl/logic_eval_arbiter.sv | 149 ++++++++++++++
 tb/tb_logic_eval_arbiter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/logic_eval_arbiter_pkg.sv
// Shared encodings for the arbitrated f/g/h logic evaluator.
// State codes, operand field offsets and statistics width.
package logic_eval_arbiter_pkg;

  localparam int STAT_W = 16;

  localparam int X1_LSB = 0;
  localparam int X2_LSB = 2;
  localparam int X3_LSB = 4;
  localparam int X4_LSB = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/logic_eval_arbiter_fgh.sv
// Gate-level f/g/h evaluator on one packed operand set {x4,x3,x2,x1}.
// f = g | h; g and h are the two second-level terms.
module fgh_eval
  import logic_eval_arbiter_pkg::*;
(
  input  logic [7:0] i_x,
  output logic       o_f,
  output logic       o_g,
  output logic       o_h
);

  logic [1:0] w_x1, w_x2, w_x3, w_x4;
  wire w_nx2, w_nx3;
  wire w_g0, w_g1, w_h0, w_h1;
  wire w_f, w_g, w_h;

  assign w_x1 = i_x[X1_LSB +: 2];
  assign w_x2 = i_x[X2_LSB +: 2];
  assign w_x3 = i_x[X3_LSB +: 2];
  assign w_x4 = i_x[X4_LSB +: 2];

  not u_n0 (w_nx3, w_x3[1]);
  not u_n1 (w_nx2, w_x2[1]);

  and u_a0 (w_g0, w_x1[0], w_x3[0]);
  and u_a1 (w_g1, w_x2[0], w_x4[0]);
  or  u_o0 (w_g, w_g0, w_g1);

  or  u_o1 (w_h0, w_x1[1], w_nx3);
  or  u_o2 (w_h1, w_nx2, w_x4[1]);
  and u_a2 (w_h, w_h0, w_h1);

  or  u_o3 (w_f, w_g, w_h);

  assign o_f = w_f;
  assign o_g = w_g;
  assign o_h = w_h;

endmodule

// File: rtl/logic_eval_arbiter.sv
// Round-robin shared f/g/h evaluator: IDLE -> EVAL -> DONE handshake.
// Optional saturating statistics under LOGIC_EVAL_STATS_EN.
module logic_eval_arbiter
  import logic_eval_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_x,
  output logic [NREQ-1:0]   gnt,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [IDW-1:0]    res_id,
  output logic              res_f,
  output logic              res_g,
  output logic              res_h,
  output logic [STAT_W-1:0] stat_total,
  output logic [STAT_W-1:0] stat_ones
);

  state_t          r_state, w_state_n;
  logic [IDW-1:0]  r_rr, w_rr_n;
  logic [7:0]      r_opnd, w_opnd_n;
  logic [NREQ-1:0] r_gnt, w_gnt_n;
  logic            r_valid, w_valid_n;
  logic [IDW-1:0]  r_id, w_id_n;
  logic            r_f, r_g, r_h;
  logic            w_f_n, w_g_n, w_h_n;
  logic            w_found;
  logic [IDW-1:0]  w_win;
  logic            w_f, w_g, w_h;

  fgh_eval u_fgh (
    .i_x (r_opnd),
    .o_f (w_f),
    .o_g (w_g),
    .o_h (w_h)
  );

  // first requester at or after the rr pointer, wrapping
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(r_rr) + k) % NREQ;
      if (!w_found && req[idx]) begin
        w_found = 1'b1;
        w_win   = IDW'(idx);
      end
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_rr_n    = r_rr;
    w_opnd_n  = r_opnd;
    w_gnt_n   = '0;
    w_valid_n = r_valid;
    w_id_n    = r_id;
    w_f_n     = r_f;
    w_g_n     = r_g;
    w_h_n     = r_h;
    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          w_opnd_n  = req_x[8*w_win +: 8];
          w_id_n    = w_win;
          w_gnt_n   = NREQ'(1) << w_win;
          w_state_n = EVAL;
          w_rr_n    = (w_win == IDW'(NREQ-1))
                    ? '0 : w_win + 1'b1;
        end
      end
      EVAL: begin
        w_f_n     = w_f;
        w_g_n     = w_g;
        w_h_n     = w_h;
        w_valid_n = 1'b1;
        w_state_n = DONE;
      end
      DONE: begin
        if (res_ready) begin
          w_valid_n = 1'b0;
          w_state_n = IDLE;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_rr    <= '0;
      r_opnd  <= '0;
      r_gnt   <= '0;
      r_valid <= 1'b0;
      r_id    <= '0;
      r_f     <= 1'b0;
      r_g     <= 1'b0;
      r_h     <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_rr    <= w_rr_n;
      r_opnd  <= w_opnd_n;
      r_gnt   <= w_gnt_n;
      r_valid <= w_valid_n;
      r_id    <= w_id_n;
      r_f     <= w_f_n;
      r_g     <= w_g_n;
      r_h     <= w_h_n;
    end
  end

`ifdef LOGIC_EVAL_STATS_EN
  logic              w_xfer;
  logic [STAT_W-1:0] r_total, r_ones;

  assign w_xfer = (r_state == DONE) && res_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_total <= '0;
      r_ones  <= '0;
    end else if (w_xfer) begin
      if (r_total != '1) r_total <= r_total + 1'b1;
      if (r_f && r_ones != '1) r_ones <= r_ones + 1'b1;
    end
  end

  assign stat_total = r_total;
  assign stat_ones  = r_ones;
`else
  assign stat_total = '0;
  assign stat_ones  = '0;
`endif

  assign gnt       = r_gnt;
  assign res_valid = r_valid;
  assign res_id    = r_id;
  assign res_f     = r_f;
  assign res_g     = r_g;
  assign res_h     = r_h;

endmodule

// File: tb/tb_logic_eval_arbiter.sv
// Directed bench for logic_eval_arbiter: handshake, stall, reset abort,
// round-robin rotation and (with LOGIC_EVAL_STATS_EN) statistics.
module tb_logic_eval_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_x;
  logic [3:0]  gnt;
  logic        res_valid;
  logic        res_ready;
  logic [1:0]  res_id;
  logic        res_f, res_g, res_h;
  logic [15:0] stat_total, stat_ones;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] exp_f_tab;
  int         slot;

  logic_eval_arbiter #(.NREQ(4), .IDW(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_x      (req_x),
    .gnt        (gnt),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_id     (res_id),
    .res_f      (res_f),
    .res_g      (res_g),
    .res_h      (res_h),
    .stat_total (stat_total),
    .stat_ones  (stat_ones)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic [1:0] id,
                         input logic f, input logic g, input logic h);
    chk({tag, "_valid"}, 32'(res_valid), 32'd1);
    chk({tag, "_id"}, 32'(res_id), 32'(id));
    chk({tag, "_fgh"}, 32'({res_f, res_g, res_h}), 32'({f, g, h}));
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = '0;
    req_x     = '0;
    res_ready = 1'b0;
    #2;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_id", 32'(res_id), 32'd0);
    chk("rst_fgh", 32'({res_f, res_g, res_h}), 32'd0);
    chk("rst_stat", {stat_total, stat_ones}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // requester 1, x1=01 x3=01: g=1 h=1 f=1
    req = 4'b0010;
    req_x[15:8] = 8'h11;
    tick();
    chk("t1_gnt", 32'(gnt), 32'b0010);
    chk("t1_nvalid", 32'(res_valid), 32'd0);
    req = '0;
    req_x = '0;
    tick();
    chk("t1_gnt_off", 32'(gnt), 32'd0);
    chk_res("t1", 2'd1, 1'b1, 1'b1, 1'b1);
    res_ready = 1'b1;
    tick();
    chk("t1_drop", 32'(res_valid), 32'd0);
    res_ready = 1'b0;

    // requester 0, x3=10: g=0 h=0 f=0; then 5-cycle stall
    req = 4'b0001;
    req_x[7:0] = 8'h20;
    tick();
    chk("t2_gnt", 32'(gnt), 32'b0001);
    req = '0;
    tick();
    chk_res("t2", 2'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) req = 4'b1000;
      if (i == 3) req = '0;
      tick();
      chk_res("t2_stall", 2'd0, 1'b0, 1'b0, 1'b0);
      chk("t2_stall_gnt", 32'(gnt), 32'd0);
    end
    res_ready = 1'b1;
    tick();
    chk("t2_drop", 32'(res_valid), 32'd0);
    res_ready = 1'b0;

    // requester 2, 8'h05 (x1=01 x2=01): g=0 h=1 f=1
    req = 4'b0100;
    req_x = '0;
    req_x[23:16] = 8'h05;
    tick();
    chk("t3_gnt", 32'(gnt), 32'b0100);
    req = '0;
    tick();
    chk_res("t3", 2'd2, 1'b1, 1'b0, 1'b1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
`ifdef LOGIC_EVAL_STATS_EN
    chk("stat3_total", 32'(stat_total), 32'd3);
    chk("stat3_ones", 32'(stat_ones), 32'd2);
`else
    chk("stat3_total", 32'(stat_total), 32'd0);
    chk("stat3_ones", 32'(stat_ones), 32'd0);
`endif

    // reset during EVAL aborts; rr pointer returns to 0
    req = 4'b1000;
    req_x[31:24] = 8'hFF;
    tick();
    chk("t4_gnt", 32'(gnt), 32'b1000);
    rst_n = 1'b0;
    req = '0;
    #1;
    chk("t4_abort_gnt", 32'(gnt), 32'd0);
    chk("t4_abort_valid", 32'(res_valid), 32'd0);
    chk("t4_abort_stat", 32'(stat_total), 32'd0);
    tick();
    chk("t4_hold_valid", 32'(res_valid), 32'd0);
    rst_n = 1'b1;

    // all four requesting: 0,1,2,3,0, one result per 3 cycles
    req_x = {8'h00, 8'h05, 8'h20, 8'h11};
    exp_f_tab = 4'b1101;
    req = 4'b1111;
    res_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      slot = n % 4;
      tick();
      chk("rot_gnt", 32'(gnt), 32'(4'b0001 << slot));
      chk("rot_nvalid", 32'(res_valid), 32'd0);
      tick();
      chk("rot_gnt_off", 32'(gnt), 32'd0);
      chk("rot_valid", 32'(res_valid), 32'd1);
      chk("rot_id", 32'(res_id), 32'(slot));
      chk("rot_f", 32'(res_f), 32'(exp_f_tab[slot]));
      tick();
      chk("rot_drop", 32'(res_valid), 32'd0);
    end
    req = '0;
    res_ready = 1'b0;
`ifdef LOGIC_EVAL_STATS_EN
    chk("stat5_total", 32'(stat_total), 32'd5);
    chk("stat5_ones", 32'(stat_ones), 32'd4);
`else
    chk("stat5_total", 32'(stat_total), 32'd0);
    chk("stat5_ones", 32'(stat_ones), 32'd0);
`endif
    tick();
    chk("idle_gnt", 32'(gnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
